// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: fetch FSM states, PC width, opcodes.
package picomips_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT_PRESS,
    WAIT_RELEASE,
    HALT
  } fetch_state_t;

  localparam int PSIZE_DEF = 5;

  localparam int OPW = 3;
  localparam logic [OPW-1:0] OP_NOP  = 3'd0;
  localparam logic [OPW-1:0] OP_ADD  = 3'd1;
  localparam logic [OPW-1:0] OP_ADDI = 3'd2;
  localparam logic [OPW-1:0] OP_MUL  = 3'd3;
  localparam logic [OPW-1:0] OP_LOAD = 3'd4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Decoder/button-facing bundle of the PC fetch-control stage.
interface pc_fetch_ctrl_if #(
  parameter int PSIZE = picomips_pkg::PSIZE_DEF
);
  logic             PCincr;
  logic             load_req;
  logic             btn;
  logic [PSIZE-1:0] PCout;
  logic             load_en;
  logic             halted;

  modport master (
    output PCincr, load_req, btn,
    input  PCout, load_en, halted
  );

  modport slave (
    input  PCincr, load_req, btn,
    output PCout, load_en, halted
  );
endinterface

// File: rtl/pc_fetch_ctrl_sync_edge.sv
// Button synchroniser chain followed by a rising-edge detector.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sh;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh   <= '0;
      prev <= 1'b0;
    end else begin
      sh   <= {sh[SYNC_STAGES-2:0], btn};
      prev <= sh[SYNC_STAGES-1];
    end
  end

  assign btn_s = sh[SYNC_STAGES-1];
  assign rise  = btn_s & ~prev;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and LOAD-stall fetch control.
// Define PC_WRAP_EN to wrap PC past PROG_LAST instead of halting.
module pc_fetch_ctrl
  import picomips_pkg::*;
#(
  parameter int PSIZE       = PSIZE_DEF,
  parameter int PROG_LAST   = 2**PSIZE-1,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  pc_fetch_ctrl_if.slave f
);
  localparam logic [PSIZE-1:0] LAST = PSIZE'(PROG_LAST);

  fetch_state_t     state, state_n;
  logic [PSIZE-1:0] pc, pc_n;
  logic             halted, halted_n;
  logic             le, le_n;
  logic             btn_s, rise;
  logic             adv;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .btn  (f.btn),
    .btn_s(btn_s),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      pc     <= '0;
      halted <= 1'b0;
      le     <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      halted <= halted_n;
      le     <= le_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    halted_n = halted;
    le_n     = 1'b0;
    adv      = 1'b0;
    unique case (state)
      RUN: begin
        if (f.load_req)
          state_n = WAIT_PRESS;
        else if (f.PCincr)
          adv = 1'b1;
      end
      WAIT_PRESS: begin
        if (rise) begin
          le_n    = 1'b1;
          state_n = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!btn_s) begin
          state_n = RUN;
          adv     = 1'b1;
        end
      end
      HALT: ;
      default: state_n = RUN;
    endcase
    // Shared advance rule for RUN and for leaving WAIT_RELEASE
    if (adv) begin
      if (pc == LAST) begin
`ifdef PC_WRAP_EN
        pc_n = '0;
`else
        state_n  = HALT;
        halted_n = 1'b1;
`endif
      end else begin
        pc_n = pc + 1'b1;
      end
    end
  end

  assign f.PCout   = pc;
  assign f.load_en = le;
  assign f.halted  = halted;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus random checks of pc_fetch_ctrl against a cycle model.
module tb_pc_fetch_ctrl;
  localparam int PS   = 3;
  localparam int LAST = 7;
  localparam int S    = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;

  pc_fetch_ctrl_if #(.PSIZE(PS)) fi ();

  pc_fetch_ctrl #(
    .PSIZE      (PS),
    .PROG_LAST  (LAST),
    .SYNC_STAGES(S)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .f    (fi)
  );

  always #5 clk = ~clk;

  // Reference: PC value, halted flag, pending pulse, activity mode
  // (0 fetching, 1 awaiting press, 2 awaiting release, 3 stopped)
  int m_pc, m_halt, m_le, m_mode;
  bit hist[S+1];

  task automatic advance();
    if (m_pc == LAST) begin
`ifdef PC_WRAP_EN
      m_pc = 0;
`else
      m_mode = 3;
      m_halt = 1;
`endif
    end else begin
      m_pc = m_pc + 1;
    end
  endtask

  task automatic model_step();
    bit bs, rise;
    bs   = hist[1];
    rise = hist[1] && !hist[0];
    if (reset) begin
      m_pc = 0; m_halt = 0; m_le = 0; m_mode = 0;
      for (int i = 0; i <= S; i++) hist[i] = 1'b0;
      return;
    end
    m_le = 0;
    case (m_mode)
      0: if (fi.load_req) m_mode = 1;
         else if (fi.PCincr) advance();
      1: if (rise) begin m_le = 1; m_mode = 2; end
      2: if (!bs) begin m_mode = 0; advance(); end
      default: ;
    endcase
    for (int i = 0; i < S; i++) hist[i] = hist[i+1];
    hist[S] = fi.btn;
  endtask

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", int'(fi.PCout), m_pc);
    chk("load_en", int'(fi.load_en), m_le);
    chk("halted", int'(fi.halted), m_halt);
  endtask

  task automatic drive(bit r, bit inc, bit lr, bit b);
    reset = r; fi.PCincr = inc; fi.load_req = lr; fi.btn = b;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    cyc(); cyc();
    reset = 0;
  endtask

  int n, pulses;

  initial begin
    for (int i = 0; i <= S; i++) hist[i] = 1'b0;
    m_pc = 0; m_halt = 0; m_le = 0; m_mode = 0;
    drive(1, 0, 0, 0);
    @(negedge clk);

    do_reset();
    chk("reset_pc", int'(fi.PCout), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0); cyc();
      chk("count_pc", int'(fi.PCout), i + 1);
    end

    do_reset();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0); cyc(); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0); cyc();
      chk("nop_hold", int'(fi.PCout), 3);
    end

    do_reset();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 0, 0); cyc(); end
    drive(0, 1, 1, 0); cyc();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 1, 0); cyc(); end
    chk("stall_pc", int'(fi.PCout), 2);
    n = 0; pulses = 0;
    drive(0, 1, 1, 1);
    while (n < 10 && !fi.load_en) begin cyc(); n++; end
    chk("press_lat", n, S + 1);
    pulses = int'(fi.load_en);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 1); cyc();
      pulses += int'(fi.load_en);
    end
    chk("one_pulse", pulses, 1);
    chk("held_pc", int'(fi.PCout), 2);
    n = 0;
    drive(0, 0, 0, 0);
    while (n < 10 && fi.PCout == 3'd2) begin cyc(); n++; end
    chk("release_lat", n, S + 1);
    chk("release_pc", int'(fi.PCout), 3);

    do_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1); cyc(); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 1); cyc();
      pulses += int'(fi.load_en);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0); cyc();
      pulses += int'(fi.load_en);
    end
    chk("stale_btn", pulses, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1); cyc();
      pulses += int'(fi.load_en);
    end
    chk("fresh_press", pulses, 1);
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0); cyc(); end
    chk("fresh_pc", int'(fi.PCout), 1);

    do_reset();
    for (int i = 0; i < 7; i++) begin drive(0, 1, 0, 0); cyc(); end
    chk("at_last", int'(fi.PCout), 7);
    drive(0, 1, 0, 0); cyc();
`ifdef PC_WRAP_EN
    chk("wrap_pc", int'(fi.PCout), 0);
    chk("wrap_halt", int'(fi.halted), 0);
`else
    chk("halt_flag", int'(fi.halted), 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, i[0], i[1]); cyc();
    end
    chk("halt_pc", int'(fi.PCout), 7);
`endif

    do_reset();
    for (int i = 0; i < 5; i++) begin drive(0, 1, 0, 0); cyc(); end
    drive(0, 0, 1, 0); cyc();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 1); cyc(); end
    chk("wr_pc", int'(fi.PCout), 5);
    drive(1, 1, 1, 1); cyc();
    chk("rst_pc", int'(fi.PCout), 0);
    chk("rst_le", int'(fi.load_en), 0);
    drive(0, 1, 0, 0); cyc();
    chk("rst_run", int'(fi.PCout), 1);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) fi.btn = ~fi.btn;
      reset       = ($urandom_range(0, 79) == 0);
      fi.PCincr   = ($urandom_range(0, 1) == 1);
      fi.load_req = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
